instr_dec_stage: RTL and testbench
==================================

// Module: instr_dec_stage
// PURPOSE
//  Registered instruction-decode stage with valid/ready handshake and DEPTH-entry skid buffer.
//  Sits between fetch and register-file/ALU control in the pipelined processor.
//  Stores raw {Instr, PC}; splits the head entry into OPcode/RS/RT/RD/shamt/Func/Imm/Jumpt.
//  Also classifies the type and produces an extended immediate and a jump target.
// PARAMETERS
//  WL     32  data/instruction/PC width; must be >= 32, field slicing uses Instr[31:0]
//  DEPTH  2   buffer entries; power of two, >= 2
// PORTS
//  CLK       in   1      clock, rising edge
//  RST       in   1      asynchronous, active-high reset
//  Flush     in   1      synchronous clear of all buffered entries
//  in_valid  in   1      upstream has Instr/PC
//  in_ready  out  1      stage can accept (count < DEPTH)
//  Instr     in   WL     instruction word
//  PC        in   WL     address of Instr
//  out_valid out  1      head entry valid
//  out_ready in   1      downstream consumes head
//  OPcode    out  6      head Instr[31:26]
//  RS        out  5      head Instr[25:21]
//  RT        out  5      head Instr[20:16]
//  RD        out  5      head Instr[15:11]
//  shamt     out  5      head Instr[10:6]
//  Func      out  6      head Instr[5:0]
//  Imm       out  16     head Instr[15:0]
//  Jumpt     out  26     head Instr[25:0]
//  Type      out  2      0=R (op 0x00), 2=J (op 0x02/0x03), 1=I (all others), 3 unused
//  ImmExt    out  WL     zero-extend Imm for op 0x0C/0x0D/0x0E; else sign-extend
//  JumpAddr  out  WL     {(PC+4)[31:28], Jumpt, 2'b00}, upper bits above 31 zero
// BEHAVIOUR
//  Reset: count=0, rd/wr pointers=0, all storage 0.
//  Reset outputs: out_valid=0, in_ready=1, decoded outputs 0.
//  Push when in_valid&in_ready; pop when out_valid&out_ready; both may occur in one cycle.
//  Simultaneous push+pop leaves count unchanged; pointers wrap modulo DEPTH.
//  Latency: entry pushed at edge N into an empty buffer gives out_valid=1 after edge N.
//  No combinational in->out path.
//  in_ready=(count<DEPTH) and depends only on registered count.
//  Full: in_ready=0 even if a pop occurs in the same cycle.
//  Empty: out_valid=0; decoded outputs hold the last head slot contents (don't-care).
//  Hold: out_valid&!out_ready keeps the head and all outputs stable.
//  Flush: next edge sets count=0, pointers=0, out_valid=0.
//  Flush beats a simultaneous push and pop; the pushed word is dropped.
//  RST asserted mid-transfer: immediate async clear, identical to reset state.
//  Decode is combinational from the head entry only; no per-field registers.
// CONFIGURATION
//  INSTR_DEC_ILLEGAL_EN defined:
//   adds output Illegal (1 bit, reset 0).
//   Illegal = out_valid & (op not in {00,02,03,04,05,08,09,0A,0B,0C,0D,0E,0F,23,2B}
//             | (op==00 & Func not in {00,02,08,20,21,22,23,24,25,26,27,2A,2B})).
//   Illegal entries still flow normally.
//  INSTR_DEC_ILLEGAL_EN undefined: port Illegal absent; no check logic.
// TESTING
//  1 Reset then push Instr=0x8AA9AB1A, PC=0 -> next cycle out_valid=1, OPcode=0x22, RS=21, RT=9.
//    Same entry -> RD=21, shamt=12, Func=0x1A, Jumpt=0x2A9AB1A, Type=1, ImmExt=0xFFFFAB1A.
//    Same entry -> Illegal=1 when INSTR_DEC_ILLEGAL_EN defined.
//  2 Push 0x3401FFFF (ori) -> ImmExt=0x0000FFFF, Type=1.
//    Push 0x08000010 with PC=0x00400000 -> Type=2, JumpAddr=0x00000040.
//  3 out_ready=0, push DEPTH words -> in_ready=0 after the DEPTH-th push, first word held stable.
//    Then out_ready=1 -> words drain in order, one per cycle.
//  4 Streaming push+pop every cycle with 1 entry buffered -> count constant, no bubbles.
//    Pointer wrap gives no reordering over 3*DEPTH words.
//  5 Flush with buffer full plus simultaneous push -> out_valid=0 and in_ready=1 next cycle.
//    Flushed words and the pushed word are never output.
//  6 RST pulse between edges while out_valid=1 -> out_valid=0 and in_ready=1 immediately.
//    After RST release, the next push appears after one edge.

Source files
------------

// File: rtl/instr_dec_stage.sv
// Registered instruction-decode stage: DEPTH-entry {Instr, PC} skid buffer with valid/ready
// handshake and combinational field decode of the head entry. Optional macro: INSTR_DEC_ILLEGAL_EN.
module instr_dec_stage #(
    parameter int WL    = 32,
    parameter int DEPTH = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          Flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WL-1:0] Instr,
    input  logic [WL-1:0] PC,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [5:0]    OPcode,
    output logic [4:0]    RS,
    output logic [4:0]    RT,
    output logic [4:0]    RD,
    output logic [4:0]    shamt,
    output logic [5:0]    Func,
    output logic [15:0]   Imm,
    output logic [25:0]   Jumpt,
    output logic [1:0]    Type,
    output logic [WL-1:0] ImmExt,
    output logic [WL-1:0] JumpAddr
`ifdef INSTR_DEC_ILLEGAL_EN
    ,
    output logic          Illegal
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WL-1:0]    instr_q [DEPTH];
    logic [WL-1:0]    instr_d [DEPTH];
    logic [WL-1:0]    pc_q    [DEPTH];
    logic [WL-1:0]    pc_d    [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] wr_en;
    logic             push, pop;

    // Handshake flags come only from registered state, so there is no in->out path.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push & ~Flush & (wr_ptr_q == PW'(gi));
        end
    endgenerate

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            instr_d[i] = wr_en[i] ? Instr : instr_q[i];
            pc_d[i]    = wr_en[i] ? PC    : pc_q[i];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= instr_d[i];
                pc_q[i]    <= pc_d[i];
            end
        end
    end

    logic [WL-1:0] head_instr, head_pc;
    logic [31:0]   ir, pc_plus4;
    logic          zero_ext;

    assign head_instr = instr_q[rd_ptr_q];
    assign head_pc    = pc_q[rd_ptr_q];
    assign ir         = head_instr[31:0];
    assign pc_plus4   = head_pc[31:0] + 32'd4;

    assign OPcode = ir[31:26];
    assign RS     = ir[25:21];
    assign RT     = ir[20:16];
    assign RD     = ir[15:11];
    assign shamt  = ir[10:6];
    assign Func   = ir[5:0];
    assign Imm    = ir[15:0];
    assign Jumpt  = ir[25:0];

    // andi/ori/xori take a zero-extended immediate; everything else sign-extends.
    assign zero_ext = (ir[31:26] == 6'h0C) || (ir[31:26] == 6'h0D) || (ir[31:26] == 6'h0E);

    always_comb begin
        Type = 2'd1;
        if (ir[31:26] == 6'h00)
            Type = 2'd0;
        else if ((ir[31:26] == 6'h02) || (ir[31:26] == 6'h03))
            Type = 2'd2;
    end

    assign ImmExt   = zero_ext ? {{(WL-16){1'b0}}, ir[15:0]} : {{(WL-16){ir[15]}}, ir[15:0]};
    assign JumpAddr = WL'({pc_plus4[31:28], ir[25:0], 2'b00});

`ifdef INSTR_DEC_ILLEGAL_EN
    logic legal_op, legal_fn;

    always_comb begin
        legal_op = 1'b0;
        legal_fn = 1'b0;
        case (ir[31:26])
            6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
            6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: legal_op = 1'b1;
            default: legal_op = 1'b0;
        endcase
        case (ir[5:0])
            6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
            6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: legal_fn = 1'b1;
            default: legal_fn = 1'b0;
        endcase
    end

    assign Illegal = out_valid & (~legal_op | ((ir[31:26] == 6'h00) & ~legal_fn));
`endif

endmodule

// File: tb/tb_instr_dec_stage.sv
// Self-checking bench for instr_dec_stage: decode vector table plus fill/hold/drain, streaming,
// flush and async-reset sequences, all checked through an expected-result scoreboard.
module tb_instr_dec_stage;

    localparam int WL    = 32;
    localparam int DEPTH = 2;

    logic          CLK, RST, Flush, in_valid, in_ready, out_valid, out_ready;
    logic [WL-1:0] Instr, PC, ImmExt, JumpAddr;
    logic [5:0]    OPcode, Func;
    logic [4:0]    RS, RT, RD, shamt;
    logic [15:0]   Imm;
    logic [25:0]   Jumpt;
    logic [1:0]    Type;
`ifdef INSTR_DEC_ILLEGAL_EN
    logic          Illegal;
`endif

    instr_dec_stage #(.WL(WL), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready), .Instr(Instr), .PC(PC),
        .out_valid(out_valid), .out_ready(out_ready),
        .OPcode(OPcode), .RS(RS), .RT(RT), .RD(RD), .shamt(shamt), .Func(Func),
        .Imm(Imm), .Jumpt(Jumpt), .Type(Type), .ImmExt(ImmExt), .JumpAddr(JumpAddr)
`ifdef INSTR_DEC_ILLEGAL_EN
        , .Illegal(Illegal)
`endif
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [1:0]  typ;
        logic [31:0] immext;
        logic [31:0] jaddr;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr, pc;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [1:0]  typ;
        logic [31:0] immext, jaddr;
        logic        ill;
    } vec_t;

    exp_t sb[$];
    exp_t drv_exp;
    int   checks = 0;
    int   errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
        exp_t e;
        logic [31:0] p4;
        e.instr = i;
        e.pc    = p;
        e.op    = i[31:26];
        e.rs    = i[25:21];
        e.rt    = i[20:16];
        e.rd    = i[15:11];
        e.sh    = i[10:6];
        e.fn    = i[5:0];
        e.imm   = i[15:0];
        e.jt    = i[25:0];
        e.typ   = (e.op == 6'h00) ? 2'd0 : ((e.op == 6'h02 || e.op == 6'h03) ? 2'd2 : 2'd1);
        e.immext = (e.op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0, i[15:0]} : {{16{i[15]}}, i[15:0]};
        p4      = p + 32'd4;
        e.jaddr = {p4[31:28], i[25:0], 2'b00};
        e.ill   = !(e.op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                                 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B})
                  || (e.op == 6'h00 && !(e.fn inside {6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22,
                                                      6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B}));
        return e;
    endfunction

    // Scoreboard: at each falling edge, decide what the coming rising edge will pop and push.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (Flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual=%h required=none", OPcode);
                    end else begin
                        e = sb.pop_front();
                        $display("POP instr=%h pc=%h", e.instr, e.pc);
                        chk("OPcode", OPcode, e.op);
                        chk("RS", RS, e.rs);
                        chk("RT", RT, e.rt);
                        chk("RD", RD, e.rd);
                        chk("shamt", shamt, e.sh);
                        chk("Func", Func, e.fn);
                        chk("Imm", Imm, e.imm);
                        chk("Jumpt", Jumpt, e.jt);
                        chk("Type", Type, e.typ);
                        chk("ImmExt", ImmExt, e.immext);
                        chk("JumpAddr", JumpAddr, e.jaddr);
`ifdef INSTR_DEC_ILLEGAL_EN
                        chk("Illegal", Illegal, e.ill);
`endif
                    end
                end
                if (in_valid && in_ready) sb.push_back(drv_exp);
            end
        end
    end

    always @(posedge RST) sb.delete();

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p, input exp_t e);
        in_valid = 1'b1;
        Instr    = i;
        PC       = p;
        drv_exp  = e;
    endtask

    task automatic drive_rand();
        logic [31:0] i, p;
        i = $urandom;
        p = $urandom;
        p[1:0] = 2'b00;
        drive(i, p, model(i, p));
    endtask

    vec_t vecs[8];

    initial begin
        exp_t e;
        vecs[0] = '{32'h8AA9AB1A, 32'h00000000, 6'h22, 5'd21, 5'd9,  5'd21, 5'd12, 6'h1A, 2'd1, 32'hFFFFAB1A, 32'h0AA6AC68, 1'b1};
        vecs[1] = '{32'h3401FFFF, 32'h00000000, 6'h0D, 5'd0,  5'd1,  5'd31, 5'd31, 6'h3F, 2'd1, 32'h0000FFFF, 32'h0007FFFC, 1'b0};
        vecs[2] = '{32'h08000010, 32'h00400000, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h10, 2'd2, 32'h00000010, 32'h00000040, 1'b0};
        vecs[3] = '{32'h012A4020, 32'hF0000000, 6'h00, 5'd9,  5'd10, 5'd8,  5'd0,  6'h20, 2'd0, 32'h00004020, 32'hF4A90080, 1'b0};
        vecs[4] = '{32'h0C000001, 32'h0FFFFFFC, 6'h03, 5'd0,  5'd0,  5'd0,  5'd0,  6'h01, 2'd2, 32'h00000001, 32'h10000004, 1'b0};
        vecs[5] = '{32'h30008000, 32'h00000000, 6'h0C, 5'd0,  5'd0,  5'd16, 5'd0,  6'h00, 2'd1, 32'h00008000, 32'h00020000, 1'b0};
        vecs[6] = '{32'h20008000, 32'h00000000, 6'h08, 5'd0,  5'd0,  5'd16, 5'd0,  6'h00, 2'd1, 32'hFFFF8000, 32'h00020000, 1'b0};
        vecs[7] = '{32'h00000001, 32'h00000000, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0,  6'h01, 2'd0, 32'h00000001, 32'h00000004, 1'b1};

        RST = 1'b1; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Instr = '0; PC = '0; drv_exp = '0;
        tick();
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_OPcode", OPcode, 0);
        chk("rst_RD", RD, 0);
        chk("rst_Type", Type, 0);
        chk("rst_ImmExt", ImmExt, 0);
        chk("rst_JumpAddr", JumpAddr, 0);
`ifdef INSTR_DEC_ILLEGAL_EN
        chk("rst_Illegal", Illegal, 0);
`endif
        tick();

        // Decode vector table, streamed back to back
        out_ready = 1'b1;
        foreach (vecs[k]) begin
            e = '0;
            e.instr = vecs[k].instr;  e.pc = vecs[k].pc;   e.op = vecs[k].op;
            e.rs = vecs[k].rs;        e.rt = vecs[k].rt;   e.rd = vecs[k].rd;
            e.sh = vecs[k].sh;        e.fn = vecs[k].fn;   e.typ = vecs[k].typ;
            e.immext = vecs[k].immext; e.jaddr = vecs[k].jaddr; e.ill = vecs[k].ill;
            e.imm = vecs[k].instr[15:0];
            e.jt  = vecs[k].instr[25:0];
            drive(vecs[k].instr, vecs[k].pc, e);
            @(negedge CLK);
            if (k > 0) chk("tbl_out_valid", out_valid, 1);
            tick();
        end
        in_valid = 1'b0;
        @(negedge CLK); chk("tbl_tail_valid", out_valid, 1); tick();
        @(negedge CLK); chk("tbl_empty", out_valid, 0); tick();

        // Fill to full with no consumer, hold, then drain in order
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            drive_rand();
            @(negedge CLK);
            chk("fill_in_ready", in_ready, 1);
            tick();
        end
        for (int h = 0; h < 3; h++) begin
            drive_rand();
            @(negedge CLK);
            chk("full_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_OPcode", OPcode, sb[0].op);
            chk("hold_ImmExt", ImmExt, sb[0].immext);
            chk("hold_JumpAddr", JumpAddr, sb[0].jaddr);
            tick();
        end
        out_ready = 1'b1;
        drive_rand();
        @(negedge CLK);
        chk("full_pop_in_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            @(negedge CLK); chk("drain_out_valid", out_valid, 1); tick();
        end
        @(negedge CLK); chk("drain_empty", out_valid, 0); tick();

        // Streaming with one entry buffered, covering several pointer wraps
        out_ready = 1'b0;
        drive_rand();
        @(negedge CLK); tick();
        out_ready = 1'b1;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            drive_rand();
            @(negedge CLK);
            chk("stream_out_valid", out_valid, 1);
            chk("stream_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        @(negedge CLK); chk("stream_tail", out_valid, 1); tick();
        @(negedge CLK); chk("stream_empty", out_valid, 0); tick();

        // Flush with buffer full plus simultaneous push and pop
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            drive_rand();
            @(negedge CLK); tick();
        end
        Flush = 1'b1;
        out_ready = 1'b1;
        drive_rand();
        @(negedge CLK); tick();
        Flush = 1'b0;
        in_valid = 1'b0;
        @(negedge CLK);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        tick();
        @(negedge CLK); chk("flush_idle", out_valid, 0); tick();
        drive_rand();
        @(negedge CLK); tick();
        in_valid = 1'b0;
        @(negedge CLK); chk("post_flush_valid", out_valid, 1); tick();
        @(negedge CLK); chk("post_flush_empty", out_valid, 0); tick();

        // Asynchronous reset pulse between edges while an entry is held
        out_ready = 1'b0;
        drive_rand();
        @(negedge CLK); tick();
        in_valid = 1'b0;
        @(negedge CLK);
        chk("pre_rst_valid", out_valid, 1);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_OPcode", OPcode, 0);
        chk("async_rst_ImmExt", ImmExt, 0);
        #1 RST = 1'b0;
        tick();
        out_ready = 1'b1;
        drive_rand();
        @(negedge CLK); tick();
        in_valid = 1'b0;
        @(negedge CLK); chk("post_rst_valid", out_valid, 1); tick();
        @(negedge CLK); chk("post_rst_empty", out_valid, 0); tick();

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
